// File: rtl/register_file.sv
// register_file: bank of one-hot written registers with a combinational,
// lowest-index-priority read port onto a single shared output bus.
module register_file #(
   parameter int reg_count = 11,
   parameter int reg_width = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [reg_count-1:0] read_en,
   input  logic [reg_count-1:0] write_en,
   input  logic [reg_width-1:0] datain,
   output logic [reg_width-1:0] dataout
);

   logic [reg_width-1:0] regs [reg_count];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < reg_count; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < reg_count; i++) begin
            if (write_en[i]) begin
               regs[i] <= datain;
            end
         end
      end
   end

   // Scan high-to-low so the lowest set select is the last to assign.
   // Forcing zero under reset keeps the bus defined even if read_en is X.
   always_comb begin
      dataout = '0;
      if (reset) begin
         for (int i = reg_count - 1; i >= 0; i--) begin
            if (read_en[i]) begin
               dataout = regs[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scenario tasks push expected read values into a
// scoreboard queue and pop them when the combinational bus is sampled.
module tb_register_file;

   localparam int RC = 11;
   localparam int RW = 12;

   logic          clk;
   logic          reset;
   logic [RC-1:0] read_en;
   logic [RC-1:0] write_en;
   logic [RW-1:0] datain;
   logic [RW-1:0] dataout;

   logic [RW-1:0] model [RC];
   logic [RW-1:0] exp_q [$];
   logic [RW-1:0] exp;

   int checks = 0;
   int errors = 0;

   register_file #(
      .reg_count(RC),
      .reg_width(RW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .read_en (read_en),
      .write_en(write_en),
      .datain  (datain),
      .dataout (dataout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, time=%0t limit=200000", $time);
      $fatal(1);
   end

   task automatic do_write(input logic [RC-1:0] we, input logic [RW-1:0] d);
      @(negedge clk);
      write_en = we;
      datain   = d;
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < RC; i++) begin
            if (we[i]) model[i] = d;
         end
      end
      #1;
      write_en = '0;
   endtask

   task automatic sel_read(input int idx);
      read_en      = '0;
      read_en[idx] = 1'b1;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      read_en  = '0;
      write_en = '0;
      datain   = '0;
      for (int i = 0; i < RC; i++) model[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < RC; i++) begin
         sel_read(i);
         exp_q.push_back(12'h000);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (dataout !== exp) begin
            errors++;
            $display("FAIL reset_read[%0d]: dataout=%h expected=%h", i, dataout, exp);
         end
      end
      read_en = 'x;
      exp_q.push_back(12'h000);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataout !== exp) begin
         errors++;
         $display("FAIL reset_x_select: dataout=%h expected=%h", dataout, exp);
      end
      read_en = '0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_write_read();
      do_write(11'b00000000001, 12'h704);
      write_en = '0;
      read_en  = 11'b00000000001;
      datain   = 12'h684;
      exp_q.push_back(12'h704);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataout !== exp) begin
         errors++;
         $display("FAIL write_read_r: dataout=%h expected=%h", dataout, exp);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < RC; i++) begin
         sel_read(i);
         exp_q.push_back(i == 0 ? 12'h704 : 12'h000);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (dataout !== exp) begin
            errors++;
            $display("FAIL no_stray_store[%0d]: dataout=%h expected=%h", i, dataout, exp);
         end
      end
      read_en = '0;
   endtask

   task automatic test_broadcast();
      int idx [4] = '{0, 2, 10, 1};
      do_write(11'b10000000101, 12'hABC);
      for (int k = 0; k < 4; k++) begin
         sel_read(idx[k]);
         exp_q.push_back(idx[k] == 1 ? 12'h000 : 12'hABC);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (dataout !== exp) begin
            errors++;
            $display("FAIL broadcast[%0d]: dataout=%h expected=%h", idx[k], dataout, exp);
         end
      end
      read_en = '0;
   endtask

   task automatic test_priority();
      logic [RC-1:0] sel [4];
      logic [RW-1:0] want [4];
      do_write(11'b00000001000, 12'h111);
      do_write(11'b00000100000, 12'h222);
      sel[0] = 11'b00000101000; want[0] = 12'h111;
      sel[1] = 11'b00000000000; want[1] = 12'h000;
      sel[2] = 11'b11111111111; want[2] = 12'hABC;
      sel[3] = 11'b00000100010; want[3] = 12'h000;
      for (int k = 0; k < 4; k++) begin
         read_en = sel[k];
         exp_q.push_back(want[k]);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (dataout !== exp) begin
            errors++;
            $display("FAIL priority[%0d] sel=%b: dataout=%h expected=%h", k, sel[k], dataout, exp);
         end
      end
      read_en = '0;
   endtask

   task automatic test_rdw();
      do_write(11'b00000010000, 12'h055);
      @(negedge clk);
      read_en  = 11'b00000010000;
      write_en = 11'b00000010000;
      datain   = 12'hFA0;
      exp_q.push_back(12'h055);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataout !== exp) begin
         errors++;
         $display("FAIL rdw_before: dataout=%h expected=%h", dataout, exp);
      end
      exp_q.push_back(12'hFA0);
      @(posedge clk);
      model[4] = 12'hFA0;
      #1;
      write_en = '0;
      exp = exp_q.pop_front();
      checks++;
      if (dataout !== exp) begin
         errors++;
         $display("FAIL rdw_after: dataout=%h expected=%h", dataout, exp);
      end
      read_en = '0;
   endtask

   task automatic test_back_to_back();
      logic [RW-1:0] v;
      for (int i = 0; i < RC; i++) begin
         v = RW'($urandom_range(1, 4095));
         @(negedge clk);
         write_en    = '0;
         write_en[i] = 1'b1;
         datain      = v;
         @(posedge clk);
         model[i] = v;
      end
      #1;
      write_en = '0;
      for (int i = 0; i < RC; i++) begin
         sel_read(i);
         exp_q.push_back(model[i]);
      end
      for (int i = 0; i < RC; i++) begin
         sel_read(i);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (dataout !== exp) begin
            errors++;
            $display("FAIL back_to_back[%0d]: dataout=%h expected=%h", i, dataout, exp);
         end
      end
      read_en = '0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      read_en = 11'b00000010000;
      #1;
      reset = 1'b0;
      for (int i = 0; i < RC; i++) model[i] = '0;
      exp_q.push_back(12'h000);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataout !== exp) begin
         errors++;
         $display("FAIL async_clear: dataout=%h expected=%h", dataout, exp);
      end
      do_write('1, 12'hFFF);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < RC; i++) begin
         sel_read(i);
         exp_q.push_back(model[i]);
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (dataout !== exp) begin
            errors++;
            $display("FAIL reset_write_ignored[%0d]: dataout=%h expected=%h", i, dataout, exp);
         end
      end
      @(negedge clk);
      read_en  = 11'b00010000000;
      write_en = 11'b00010000000;
      datain   = 12'h123;
      exp_q.push_back(12'h000);
      exp_q.push_back(12'h123);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (dataout !== exp) begin
         errors++;
         $display("FAIL post_reset_before_edge: dataout=%h expected=%h", dataout, exp);
      end
      @(posedge clk);
      #1;
      write_en = '0;
      exp = exp_q.pop_front();
      checks++;
      if (dataout !== exp) begin
         errors++;
         $display("FAIL post_reset_write: dataout=%h expected=%h", dataout, exp);
      end
      read_en = '0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_broadcast();
      test_priority();
      test_rdw();
      test_back_to_back();
      test_async_reset();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
